// File: rtl/quet_hienthi_led.sv
// rtl/quet_hienthi_led.sv - time-multiplexed 7-segment scan controller
// Drives one BCD nibble and active-low anodes per slot, blanks each slot start, latches updates per frame.
module quet_hienthi_led #(
  parameter int N_DIGITS  = 4,
  parameter int SCAN_DIV  = 50000,
  parameter int BLANK_CYC = 500
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [4*N_DIGITS-1:0] upd_data,
  input  logic                  upd_valid,
  output logic                  upd_ready,
  input  logic                  lzs_en,
  output logic [3:0]            data,
  output logic [N_DIGITS-1:0]   an_n,
  output logic                  frame_done
);

  localparam int CNT_W = $clog2(SCAN_DIV);
  localparam int IDX_W = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(SCAN_DIV - 1);
  localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYC - 1);
  localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(N_DIGITS - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    BLANK = 2'd1,
    SHOW  = 2'd2
  } state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [4*N_DIGITS-1:0] disp_q, disp_d;
  logic [4*N_DIGITS-1:0] pend_q, pend_d;
  logic                  upd_ready_q, upd_ready_d;
  logic [3:0]            data_q, data_d;
  logic [N_DIGITS-1:0]   an_n_q, an_n_d;
  logic                  frame_done_q, frame_done_d;

  logic                  slot_end;
  logic                  frame_end;
  logic                  move;
  logic [3:0]            cur_digit;
  logic [N_DIGITS-1:0]   supp;
  logic                  zero_above;

  assign slot_end  = (state_q == SHOW) && (cnt_q == CNT_LAST);
  assign frame_end = slot_end && (idx_q == IDX_LAST);
  // A held update is pending exactly while upd_ready is low.
  assign move      = !upd_ready_q && ((state_q == IDLE) || frame_end);
  assign cur_digit = disp_q[{idx_q, 2'b00} +: 4];

  always_comb begin
    supp       = '0;
    zero_above = 1'b1;
    for (int i = N_DIGITS - 1; i >= 1; i--) begin
      zero_above = zero_above && (disp_q[4*i +: 4] == 4'd0);
      supp[i]    = lzs_en && zero_above;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        idx_d = '0;
        cnt_d = '0;
        if (en) state_d = BLANK;
      end
      BLANK: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
          if (cnt_q == BLANK_LAST) state_d = SHOW;
        end
      end
      SHOW: begin
        if (!en) begin
          state_d = IDLE;
          idx_d   = '0;
          cnt_d   = '0;
        end else if (slot_end) begin
          state_d = BLANK;
          cnt_d   = '0;
          idx_d   = (idx_q == IDX_LAST) ? '0 : idx_q + IDX_W'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = IDLE;
        idx_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are a registered view of the current slot; dropping en blanks them at once.
  always_comb begin
    data_d       = 4'hF;
    an_n_d       = '1;
    frame_done_d = en && frame_end;
    if (en && (state_q != IDLE)) data_d = cur_digit;
    if (en && (state_q == SHOW) && !supp[idx_q]) an_n_d = ~(N_DIGITS'(1) << idx_q);
  end

  always_comb begin
    disp_d      = disp_q;
    pend_d      = pend_q;
    upd_ready_d = upd_ready_q;
    if (move) begin
      disp_d      = pend_q;
      upd_ready_d = 1'b1;
    end else if (upd_valid && upd_ready_q) begin
      pend_d      = upd_data;
      upd_ready_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      idx_q        <= '0;
      cnt_q        <= '0;
      disp_q       <= {N_DIGITS{4'hF}};
      pend_q       <= '0;
      upd_ready_q  <= 1'b1;
      data_q       <= 4'hF;
      an_n_q       <= '1;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      idx_q        <= idx_d;
      cnt_q        <= cnt_d;
      disp_q       <= disp_d;
      pend_q       <= pend_d;
      upd_ready_q  <= upd_ready_d;
      data_q       <= data_d;
      an_n_q       <= an_n_d;
      frame_done_q <= frame_done_d;
    end
  end

  assign upd_ready  = upd_ready_q;
  assign data       = data_q;
  assign an_n       = an_n_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_quet_hienthi_led.sv
// tb/tb_quet_hienthi_led.sv - scoreboard bench for quet_hienthi_led
// Frame-position reference model predicts registered outputs each edge; a monitor compares them.
module tb_quet_hienthi_led;
  localparam int ND = 4;
  localparam int SD = 8;
  localparam int BL = 2;

  logic        clk;
  logic        rst_n;
  logic        en;
  logic [15:0] upd_data;
  logic        upd_valid;
  logic        upd_ready;
  logic        lzs_en;
  logic [3:0]  data;
  logic [3:0]  an_n;
  logic        frame_done;

  quet_hienthi_led #(.N_DIGITS(ND), .SCAN_DIV(SD), .BLANK_CYC(BL)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .upd_data(upd_data), .upd_valid(upd_valid),
    .upd_ready(upd_ready), .lzs_en(lzs_en), .data(data), .an_n(an_n), .frame_done(frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] an;
    logic [3:0] dat;
    logic       fd;
    logic       rdy;
  } exp_t;

  exp_t exp_q[$];
  int   n_checks = 0;
  int   n_err    = 0;

  // Reference model: running flag plus cycle position inside the frame.
  int m_disp[ND];
  int m_pend[ND];
  bit m_pend_v;
  bit m_ready;
  bit m_run;
  int m_pos;
  bit m_took;

  task automatic model_step();
    exp_t x;
    int   slot, off;
    bit   fend, sup;
    m_took = 1'b0;
    if (!rst_n) begin
      m_run = 1'b0;
      m_pos = 0;
      for (int k = 0; k < ND; k++) m_disp[k] = 15;
      m_pend_v = 1'b0;
      m_ready  = 1'b1;
      x.an = 4'hF; x.dat = 4'hF; x.fd = 1'b0; x.rdy = 1'b1;
    end else begin
      slot = m_pos / SD;
      off  = m_pos % SD;
      fend = m_run && (m_pos == ND*SD - 1);
      sup  = 1'b0;
      if (lzs_en && slot != 0) begin
        sup = 1'b1;
        for (int j = slot; j < ND; j++) if (m_disp[j] != 0) sup = 1'b0;
      end
      x.dat = (en && m_run) ? 4'(m_disp[slot]) : 4'hF;
      x.an  = 4'hF;
      if (en && m_run && off >= BL && !sup) x.an[slot] = 1'b0;
      x.fd = en && fend;
      if (m_pend_v && (!m_run || fend)) begin
        m_disp   = m_pend;
        m_pend_v = 1'b0;
        m_ready  = 1'b1;
      end else if (upd_valid && m_ready) begin
        for (int k = 0; k < ND; k++) m_pend[k] = int'(upd_data[4*k +: 4]);
        m_pend_v = 1'b1;
        m_ready  = 1'b0;
        m_took   = 1'b1;
      end
      x.rdy = m_ready;
      if (!m_run) begin
        if (en) begin m_run = 1'b1; m_pos = 0; end
      end else if (!en) begin
        m_run = 1'b0; m_pos = 0;
      end else begin
        m_pos = (m_pos + 1) % (ND*SD);
      end
    end
    exp_q.push_back(x);
  endtask

  task automatic cyc(input logic r, input logic e, input logic v, input logic [15:0] d, input logic l);
    rst_n = r; en = e; upd_valid = v; upd_data = d; lzs_en = l;
    model_step();
    @(negedge clk);
  endtask

  task automatic run(input int n, input logic e, input logic l);
    for (int k = 0; k < n; k++) cyc(1'b1, e, 1'b0, 16'h0000, l);
  endtask

  function automatic logic [15:0] rand_digits();
    logic [15:0] v;
    for (int k = 0; k < ND; k++)
      v[4*k +: 4] = ($urandom_range(0, 1) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
    return v;
  endfunction

  always @(posedge clk) begin : monitor
    exp_t x;
    #1;
    if (exp_q.size() > 0) begin
      x = exp_q.pop_front();
      n_checks++;
      if ({an_n, data, frame_done, upd_ready} !== {x.an, x.dat, x.fd, x.rdy}) begin
        n_err++;
        $display("FAIL outputs t=%0t: got an_n=%b data=%h frame_done=%b upd_ready=%b, want an_n=%b data=%h frame_done=%b upd_ready=%b",
                 $time, an_n, data, frame_done, upd_ready, x.an, x.dat, x.fd, x.rdy);
      end
    end
  end

  initial begin
    logic        en_r, lz_r, prod_v, r;
    logic [15:0] prod_d;
    // Reset and idle
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    cyc(1'b0, 1'b0, 1'b0, 16'h0000, 1'b0);
    run(3, 1'b0, 1'b0);
    // Blank display scanning, frame pulses
    run(70, 1'b1, 1'b0);
    run(2, 1'b0, 1'b0);
    // Update in idle, then scan
    cyc(1'b1, 1'b0, 1'b1, 16'h1234, 1'b0);
    run(2, 1'b0, 1'b0);
    run(40, 1'b1, 1'b0);
    // Mid-frame update plus a stalled second update
    run(1, 1'b0, 1'b0);
    run(12, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'h5678, 1'b0);
    for (int k = 0; k < 100; k++) begin
      cyc(1'b1, 1'b1, 1'b1, 16'h9ABC, 1'b0);
      if (m_took) break;
    end
    run(70, 1'b1, 1'b0);
    // Leading-zero suppression
    run(1, 1'b0, 1'b1);
    cyc(1'b1, 1'b0, 1'b1, 16'h0070, 1'b1);
    run(2, 1'b0, 1'b1);
    run(40, 1'b1, 1'b1);
    cyc(1'b1, 1'b1, 1'b1, 16'h0000, 1'b1);
    run(70, 1'b1, 1'b1);
    // Enable dropped in SHOW of slot 2, then re-enabled
    run(1, 1'b0, 1'b0);
    run(21, 1'b1, 1'b0);
    run(3, 1'b0, 1'b0);
    run(40, 1'b1, 1'b0);
    // Reset mid-SHOW with an update pending
    run(1, 1'b0, 1'b0);
    run(4, 1'b1, 1'b0);
    cyc(1'b1, 1'b1, 1'b1, 16'h4321, 1'b0);
    run(2, 1'b1, 1'b0);
    cyc(1'b0, 1'b1, 1'b0, 16'h0000, 1'b0);
    run(40, 1'b1, 1'b0);
    // Randomized traffic
    en_r = 1'b1; lz_r = 1'b0; prod_v = 1'b0; prod_d = 16'h0000;
    for (int i = 0; i < 3000; i++) begin
      r = ($urandom_range(0, 499) != 0);
      if ($urandom_range(0, 99) == 0) en_r = ~en_r;
      if ($urandom_range(0, 199) == 0) lz_r = ~lz_r;
      if (!prod_v && $urandom_range(0, 29) == 0) begin
        prod_v = 1'b1;
        prod_d = rand_digits();
      end
      cyc(r, en_r, prod_v, prod_d, lz_r);
      if (m_took || !r) prod_v = 1'b0;
    end
    run(2, 1'b0, 1'b0);
    @(posedge clk);
    #2;
    n_checks++;
    if (exp_q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d unchecked entries, want 0", exp_q.size());
    end
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
